edge_event_arbiter: RTL and testbench

//  Multi-channel edge-event scheduler. Watches N_CH single-bit inputs and detects edges per channel

---
 rtl/edge_event_arbiter_pkg.sv | 11 +
 rtl/edge_event_arbiter_rr_arbiter.sv | 43 ++++
 rtl/edge_event_arbiter.sv | 100 ++++++++++
 tb/tb_edge_event_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_event_arbiter_pkg.sv
// Shared definitions for the edge-event arbiter: per-channel edge-detection modes.
package edge_event_arbiter_pkg;

    typedef enum logic [1:0] {
        MODE_OFF  = 2'b00,
        MODE_POS  = 2'b01,
        MODE_NEG  = 2'b10,
        MODE_BOTH = 2'b11
    } edge_mode_e;

endpackage

// File: rtl/edge_event_arbiter_rr_arbiter.sv
// Round-robin arbiter: combinational grant searching upward from ptr; ptr moves past the
// winner only when the grant is consumed (adv).
module rr_arbiter #(
    parameter  int N   = 4,
    localparam int IDW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic           adv,
    output logic [IDW-1:0] gnt_idx,
    output logic           gnt_vld
);

    logic [IDW-1:0] ptr;
    logic [IDW:0]   sum;
    logic [IDW-1:0] cand;

    // Candidate index is (ptr + k) mod N, kept in IDW+1 bits so non-power-of-two N wraps correctly.
    always_comb begin
        gnt_idx = '0;
        gnt_vld = 1'b0;
        sum     = '0;
        cand    = '0;
        for (int k = 0; k < N; k++) begin
            sum  = {1'b0, ptr} + (IDW+1)'(k);
            cand = (sum >= (IDW+1)'(N)) ? IDW'(sum - (IDW+1)'(N)) : sum[IDW-1:0];
            if (!gnt_vld && req[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (adv && gnt_vld) begin
            ptr <= (gnt_idx == IDW'(N-1)) ? '0 : gnt_idx + 1'b1;
        end
    end

endmodule

// File: rtl/edge_event_arbiter.sv
// Multi-channel edge-event scheduler: per-channel edge detection and one-deep pending slot,
// shared onto a single registered valid/ready event output via round-robin arbitration.
module edge_event_arbiter
    import edge_event_arbiter_pkg::*;
#(
    parameter  int N_CH = 4,
    localparam int IDW  = $clog2(N_CH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] din,
    input  logic            mode_wr,
    input  logic [IDW-1:0]  mode_ch,
    input  logic [1:0]      mode_val,
    output logic            evt_valid,
    input  logic            evt_ready,
    output logic [IDW-1:0]  evt_ch,
    output logic            evt_rise,
    output logic            evt_ovf,
    output logic [N_CH-1:0] pend
);

    logic [N_CH-1:0] din_q, rise, fall, hit, drain, mode_sel, clr, ovf, rise_st;
    logic [1:0]      mode_q [N_CH];
    logic            load;
    logic [IDW-1:0]  gnt_idx;
    logic            gnt_vld;

    // Handshake: an event transfers on a cycle with evt_valid & evt_ready; while evt_valid is
    // high and evt_ready low, evt_ch/evt_rise/evt_ovf hold; a new event may load every cycle.
    always_comb begin
        rise     = ~din_q & din;
        fall     = din_q & ~din;
        load     = (~evt_valid | evt_ready) & (|pend);
        hit      = '0;
        drain    = '0;
        mode_sel = '0;
        clr      = '0;
        for (int i = 0; i < N_CH; i++) begin
            hit[i]      = (rise[i] & mode_q[i][0]) | (fall[i] & mode_q[i][1]);
            drain[i]    = load && gnt_vld && (gnt_idx == IDW'(i));
            mode_sel[i] = mode_wr && (32'(mode_ch) == 32'(i));
            clr[i]      = mode_sel[i] && (mode_val == MODE_OFF);
        end
    end

    rr_arbiter #(.N(N_CH)) u_rr (
        .clk     (clk),
        .rst     (rst),
        .req     (pend),
        .adv     (load),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            din_q     <= '0;
            pend      <= '0;
            ovf       <= '0;
            rise_st   <= '0;
            evt_valid <= 1'b0;
            evt_ch    <= '0;
            evt_rise  <= 1'b0;
            evt_ovf   <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                mode_q[i] <= MODE_OFF;
            end
        end else begin
            din_q <= din;
            for (int i = 0; i < N_CH; i++) begin
                if (mode_sel[i]) begin
                    mode_q[i] <= mode_val;
                end
                // Turning a channel off discards its slot; a new edge beats a drain, and only
                // overwrites an undrained slot counts as an overflow.
                if (clr[i]) begin
                    pend[i] <= 1'b0;
                    ovf[i]  <= 1'b0;
                end else if (hit[i]) begin
                    pend[i]    <= 1'b1;
                    rise_st[i] <= rise[i];
                    ovf[i]     <= pend[i] & ~drain[i];
                end else if (drain[i]) begin
                    pend[i] <= 1'b0;
                    ovf[i]  <= 1'b0;
                end
            end
            if (load) begin
                evt_valid <= 1'b1;
                evt_ch    <= gnt_idx;
                evt_rise  <= rise_st[gnt_idx];
                evt_ovf   <= ovf[gnt_idx];
            end else if (evt_ready) begin
                evt_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Bench for edge_event_arbiter: directed vector table, hand-written corner sequences and a
// randomized run checked against a slot-level reference model.
module tb_edge_event_arbiter;
    import edge_event_arbiter_pkg::*;

    localparam int N = 4;

    logic       clk;
    logic       rst;
    logic [3:0] din;
    logic       mode_wr;
    logic [1:0] mode_ch;
    logic [1:0] mode_val;
    logic       evt_valid;
    logic       evt_ready;
    logic [1:0] evt_ch;
    logic       evt_rise;
    logic       evt_ovf;
    logic [3:0] pend;

    int n_cmp = 0;
    int n_err = 0;

    edge_event_arbiter #(.N_CH(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .mode_wr   (mode_wr),
        .mode_ch   (mode_ch),
        .mode_val  (mode_val),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_ch    (evt_ch),
        .evt_rise  (evt_rise),
        .evt_ovf   (evt_ovf),
        .pend      (pend)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       r;
        logic [3:0] d;
        logic       w;
        logic [1:0] c;
        logic [1:0] v;
        logic       rdy;
        logic       ev;
        logic [1:0] ech;
        logic       erise;
        logic       eovf;
        logic [3:0] epend;
    } vec_t;

    vec_t tbl[$];

    typedef struct {
        bit has;
        bit rise;
        bit lost;
    } slot_t;

    slot_t    slot [N];
    bit [1:0] m_mode [N];
    bit [3:0] m_last;
    bit       o_valid;
    int       o_ch;
    bit       o_rise;
    bit       o_ovf;
    int       m_ptr;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // driver: apply inputs, advance one edge, settle away from the edge
    task automatic cyc(input logic r, input logic [3:0] d, input logic w, input logic [1:0] c,
                       input logic [1:0] v, input logic rdy);
        rst       = r;
        din       = d;
        mode_wr   = w;
        mode_ch   = c;
        mode_val  = v;
        evt_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic ev, input logic [1:0] ech,
                           input logic erise, input logic eovf, input logic [3:0] epend);
        chk({tag, " valid"}, int'(evt_valid), int'(ev));
        chk({tag, " pend"}, int'(pend), int'(epend));
        if (ev) begin
            chk({tag, " ch"}, int'(evt_ch), int'(ech));
            chk({tag, " rise"}, int'(evt_rise), int'(erise));
            chk({tag, " ovf"}, int'(evt_ovf), int'(eovf));
        end
    endtask

    task automatic add(input logic r, input logic [3:0] d, input logic w, input logic [1:0] c,
                       input logic [1:0] v, input logic rdy, input logic ev, input logic [1:0] ech,
                       input logic erise, input logic eovf, input logic [3:0] epend);
        tbl.push_back('{r, d, w, c, v, rdy, ev, ech, erise, eovf, epend});
    endtask

    // Reference model: each channel owns one event slot; the output stage takes the first
    // occupied slot at or after the pointer whenever it is empty or being emptied.
    task automatic model_step(input logic r, input logic [3:0] d, input logic w,
                              input logic [1:0] c, input logic [1:0] v, input logic rdy);
        int win;
        int idx;
        bit up;
        bit dn;
        bit seen;
        win = -1;
        if (r) begin
            for (int i = 0; i < N; i++) begin
                slot[i]   = '{0, 0, 0};
                m_mode[i] = MODE_OFF;
            end
            m_last  = '0;
            o_valid = 0;
            o_ch    = 0;
            o_rise  = 0;
            o_ovf   = 0;
            m_ptr   = 0;
            return;
        end
        if (!o_valid || rdy) begin
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (win < 0 && slot[idx].has) win = idx;
            end
        end
        if (win >= 0) begin
            o_valid = 1;
            o_ch    = win;
            o_rise  = slot[win].rise;
            o_ovf   = slot[win].lost;
            m_ptr   = (win + 1) % N;
        end else if (rdy) begin
            o_valid = 0;
        end
        for (int i = 0; i < N; i++) begin
            up   = !m_last[i] && d[i];
            dn   = m_last[i] && !d[i];
            seen = (up && (m_mode[i] == MODE_POS || m_mode[i] == MODE_BOTH)) ||
                   (dn && (m_mode[i] == MODE_NEG || m_mode[i] == MODE_BOTH));
            if (w && int'(c) == i && v == MODE_OFF) begin
                slot[i] = '{0, 0, 0};
            end else if (seen) begin
                slot[i].lost = slot[i].has && (i != win);
                slot[i].has  = 1;
                slot[i].rise = up;
            end else if (i == win) begin
                slot[i] = '{0, 0, 0};
            end
        end
        if (w) m_mode[c] = v;
        m_last = d;
    endtask

    initial begin
        logic [3:0] rd;
        logic       rw;
        logic [1:0] rc;
        logic [1:0] rv;
        logic       rr;
        logic       rrst;
        logic [3:0] mp;

        // reset state
        cyc(1, 4'b0000, 0, 0, 0, 0);
        cyc(1, 4'b0000, 0, 0, 0, 0);
        chk("reset valid", int'(evt_valid), 0);
        chk("reset ch", int'(evt_ch), 0);
        chk("reset rise", int'(evt_rise), 0);
        chk("reset ovf", int'(evt_ovf), 0);
        chk("reset pend", int'(pend), 0);

        // single rise latency; held event with overflow; round-robin group with wrap
        add(0, 4'b0000, 1, 0, 2'b01, 1, 0, 0, 0, 0, 4'b0000);
        add(0, 4'b0001, 0, 0, 2'b00, 1, 0, 0, 0, 0, 4'b0001);
        add(0, 4'b0001, 0, 0, 2'b00, 1, 1, 0, 1, 0, 4'b0000);
        add(0, 4'b0001, 0, 0, 2'b00, 1, 0, 0, 0, 0, 4'b0000);
        add(0, 4'b0001, 1, 1, 2'b11, 0, 0, 0, 0, 0, 4'b0000);
        add(0, 4'b0011, 0, 0, 2'b00, 0, 0, 0, 0, 0, 4'b0010);
        add(0, 4'b0011, 0, 0, 2'b00, 0, 1, 1, 1, 0, 4'b0000);
        add(0, 4'b0001, 0, 0, 2'b00, 0, 1, 1, 1, 0, 4'b0010);
        add(0, 4'b0011, 0, 0, 2'b00, 0, 1, 1, 1, 0, 4'b0010);
        add(0, 4'b0011, 0, 0, 2'b00, 1, 1, 1, 1, 1, 4'b0000);
        add(0, 4'b0011, 0, 0, 2'b00, 1, 0, 0, 0, 0, 4'b0000);
        add(1, 4'b0000, 0, 0, 2'b00, 1, 0, 0, 0, 0, 4'b0000);
        for (int i = 0; i < N; i++) add(0, 4'b0000, 1, 2'(i), 2'b01, 1, 0, 0, 0, 0, 4'b0000);
        for (int g = 0; g < 2; g++) begin
            add(0, 4'b0000, 0, 0, 2'b00, 1, 0, 0, 0, 0, 4'b0000);
            add(0, 4'b1111, 0, 0, 2'b00, 1, 0, 0, 0, 0, 4'b1111);
            add(0, 4'b1111, 0, 0, 2'b00, 1, 1, 0, 1, 0, 4'b1110);
            add(0, 4'b1111, 0, 0, 2'b00, 1, 1, 1, 1, 0, 4'b1100);
            add(0, 4'b1111, 0, 0, 2'b00, 1, 1, 2, 1, 0, 4'b1000);
            add(0, 4'b1111, 0, 0, 2'b00, 1, 1, 3, 1, 0, 4'b0000);
            add(0, 4'b1111, 0, 0, 2'b00, 1, 0, 0, 0, 0, 4'b0000);
        end
        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].r, tbl[i].d, tbl[i].w, tbl[i].c, tbl[i].v, tbl[i].rdy);
            chk_out($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ech, tbl[i].erise, tbl[i].eovf,
                    tbl[i].epend);
        end

        // edge on ch2 in the same cycle it is drained
        cyc(1, 4'b0000, 0, 0, 0, 1);
        cyc(0, 4'b0000, 1, 2, 2'b11, 1);
        cyc(0, 4'b0100, 0, 0, 0, 0);
        chk_out("drain_a", 0, 0, 0, 0, 4'b0100);
        cyc(0, 4'b0000, 0, 0, 0, 0);
        chk_out("drain_b", 1, 2, 1, 0, 4'b0100);
        cyc(0, 4'b0000, 0, 0, 0, 1);
        chk_out("drain_c", 1, 2, 0, 0, 4'b0000);
        cyc(0, 4'b0000, 0, 0, 0, 1);
        chk_out("drain_d", 0, 0, 0, 0, 4'b0000);

        // switching ch3 off drops its pending event and later edges
        cyc(1, 4'b0000, 0, 0, 0, 0);
        cyc(0, 4'b0000, 1, 0, 2'b01, 0);
        cyc(0, 4'b0000, 1, 3, 2'b01, 0);
        cyc(0, 4'b0001, 0, 0, 0, 0);
        chk_out("off_a", 0, 0, 0, 0, 4'b0001);
        cyc(0, 4'b0001, 0, 0, 0, 0);
        chk_out("off_b", 1, 0, 1, 0, 4'b0000);
        cyc(0, 4'b1001, 0, 0, 0, 0);
        chk_out("off_c", 1, 0, 1, 0, 4'b1000);
        cyc(0, 4'b1001, 1, 3, 2'b00, 0);
        chk_out("off_d", 1, 0, 1, 0, 4'b0000);
        cyc(0, 4'b1001, 0, 0, 0, 1);
        chk_out("off_e", 0, 0, 0, 0, 4'b0000);
        for (int k = 0; k < 6; k++) begin
            cyc(0, (k % 2 == 0) ? 4'b0001 : 4'b1001, 0, 0, 0, 1);
            chk_out($sformatf("off_idle%0d", k), 0, 0, 0, 0, 4'b0000);
        end

        // reset while an event is held and another is pending
        cyc(1, 4'b0000, 0, 0, 0, 0);
        cyc(0, 4'b0000, 1, 0, 2'b01, 0);
        cyc(0, 4'b0000, 1, 1, 2'b01, 0);
        cyc(0, 4'b0001, 0, 0, 0, 0);
        cyc(0, 4'b0011, 0, 0, 0, 0);
        chk_out("mrst_a", 1, 0, 1, 0, 4'b0010);
        cyc(1, 4'b0011, 0, 0, 0, 0);
        chk_out("mrst_b", 0, 0, 0, 0, 4'b0000);
        chk("mrst ch", int'(evt_ch), 0);
        chk("mrst rise", int'(evt_rise), 0);
        for (int k = 0; k < 5; k++) begin
            cyc(0, (k % 2 == 0) ? 4'b1111 : 4'b0000, 0, 0, 0, 1);
            chk_out($sformatf("mrst_idle%0d", k), 0, 0, 0, 0, 4'b0000);
        end

        // randomized traffic against the reference model
        model_step(1, 4'b0000, 0, 0, 0, 0);
        cyc(1, 4'b0000, 0, 0, 0, 0);
        rd = 4'b0000;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 2) == 0) rd = rd ^ 4'($urandom_range(1, 15));
            rw   = ($urandom_range(0, 7) == 0);
            rc   = 2'($urandom_range(0, 3));
            rv   = 2'($urandom_range(0, 3));
            rr   = ($urandom_range(0, 3) != 0);
            rrst = ($urandom_range(0, 399) == 0);
            model_step(rrst, rd, rw, rc, rv, rr);
            cyc(rrst, rd, rw, rc, rv, rr);
            for (int i = 0; i < N; i++) mp[i] = slot[i].has;
            chk_out($sformatf("rnd%0d", n), o_valid, 2'(o_ch), o_rise, o_ovf, mp);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
